// File: rtl/cache_replace_pkg.sv
// ============================================================================
// Module  : cache_replace_pkg
// Brief   : Shared types and helpers for cache way replacement.
//           Used by both builds: REPLACE_PLRU_EN defined selects tree-PLRU,
//           otherwise per-set round-robin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_replace_pkg;

  localparam int C_MAX_WAY_NUM    = 8;
  localparam int C_MAX_PLRU_NODES = C_MAX_WAY_NUM - 1;
  localparam int C_MAX_WAY_W      = 3;

  // Per-set state is sized for the largest supported associativity.
  // Smaller configurations keep the upper bits at zero.
  typedef logic [C_MAX_PLRU_NODES-1:0] plru_vec_t;
  typedef logic [C_MAX_WAY_W-1:0]      rr_ptr_t;

  function automatic int way_width(input int way_num);
    return (way_num > 1) ? $clog2(way_num) : 1;
  endfunction

  function automatic int plru_nodes(input int way_num);
    return way_num - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/plru_tree.sv
// ============================================================================
// Module  : plru_tree
// Brief   : Combinational tree-PLRU walk (victim) and path update (next bits).
//           Only present in builds with REPLACE_PLRU_EN defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef REPLACE_PLRU_EN
module plru_tree
  import cache_replace_pkg::*;
#(
  parameter int WAY_NUM = 4,
  parameter int WAY_W   = way_width(WAY_NUM)
) (
  input  plru_vec_t        tree_in,
  input  logic [WAY_W-1:0] acc_way,
  output logic [WAY_W-1:0] victim,
  output plru_vec_t        tree_out
);

  logic [2:0] w_walk_node;
  logic       w_walk_bit;
  logic [2:0] w_upd_node;
  logic       w_upd_bit;

  // Heap walk: child of node n is 2n+1 (lower half) or 2n+2 (upper half).
  always_comb begin
    victim      = '0;
    w_walk_node = '0;
    w_walk_bit  = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      w_walk_bit              = tree_in[w_walk_node];
      victim[WAY_W-1-lvl]     = w_walk_bit;
      w_walk_node             = {w_walk_node[1:0], 1'b0} + 3'd1 + {2'b00, w_walk_bit};
    end
  end

  always_comb begin
    tree_out   = tree_in;
    w_upd_node = '0;
    w_upd_bit  = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      w_upd_bit            = acc_way[WAY_W-1-lvl];
      tree_out[w_upd_node] = ~w_upd_bit;
      w_upd_node           = {w_upd_node[1:0], 1'b0} + 3'd1 + {2'b00, w_upd_bit};
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/cache_way_replacer.sv
// ============================================================================
// Module  : cache_way_replacer
// Brief   : Per-set way replacement with invalid-first victim selection.
//           REPLACE_PLRU_EN defined: tree-PLRU; undefined: round-robin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_way_replacer
  import cache_replace_pkg::*;
#(
  parameter int WAY_NUM = 4,
  parameter int SET_NUM = 128,
  parameter int IDX_W   = $clog2(SET_NUM),
  parameter int WAY_W   = way_width(WAY_NUM)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  input  logic [IDX_W-1:0]   req_index,
  input  logic [WAY_NUM-1:0] req_way_valid,
  output logic               victim_valid,
  output logic [WAY_W-1:0]   victim_way,
  input  logic               upd_valid,
  input  logic [IDX_W-1:0]   upd_index,
  input  logic [WAY_W-1:0]   upd_way,
  input  logic               upd_fill
);

  logic             w_has_invalid;
  logic [WAY_W-1:0] w_first_invalid;
  logic [WAY_W-1:0] w_policy_victim;
  logic [WAY_W-1:0] w_victim_next;
  logic             w_same_set;

  assign w_same_set = upd_valid && (upd_index == req_index);

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    w_has_invalid   = 1'b0;
    w_first_invalid = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (!req_way_valid[i]) begin
        w_has_invalid   = 1'b1;
        w_first_invalid = WAY_W'(i);
      end
    end
  end

  assign w_victim_next = w_has_invalid ? w_first_invalid : w_policy_victim;

`ifdef REPLACE_PLRU_EN
  plru_vec_t        r_tree [SET_NUM];
  plru_vec_t        w_tree_upd_next;
  plru_vec_t        w_tree_req;
  plru_vec_t        w_unused_walk_tree;
  logic [WAY_W-1:0] w_unused_upd_victim;
  logic             w_unused_fill;

  assign w_unused_fill = upd_fill;
  assign w_tree_req    = w_same_set ? w_tree_upd_next : r_tree[req_index];

  plru_tree #(
    .WAY_NUM (WAY_NUM),
    .WAY_W   (WAY_W)
  ) u_walk (
    .tree_in  (w_tree_req),
    .acc_way  ('0),
    .victim   (w_policy_victim),
    .tree_out (w_unused_walk_tree)
  );

  plru_tree #(
    .WAY_NUM (WAY_NUM),
    .WAY_W   (WAY_W)
  ) u_update (
    .tree_in  (r_tree[upd_index]),
    .acc_way  (upd_way),
    .victim   (w_unused_upd_victim),
    .tree_out (w_tree_upd_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SET_NUM; s++) begin
        r_tree[s] <= '0;
      end
    end else if (upd_valid) begin
      r_tree[upd_index] <= w_tree_upd_next;
    end
  end
`else
  rr_ptr_t    r_rr [SET_NUM];
  rr_ptr_t    w_rr_upd_next;
  rr_ptr_t    w_rr_req;
  logic [WAY_W-1:0] w_unused_upd_way;

  assign w_unused_upd_way = upd_way;

  assign w_rr_upd_next = (r_rr[upd_index] == rr_ptr_t'(WAY_NUM - 1))
                       ? '0 : r_rr[upd_index] + rr_ptr_t'(1);

  // Hits never move the pointer, so only a same-set fill needs the bypass.
  assign w_rr_req        = (w_same_set && upd_fill) ? w_rr_upd_next : r_rr[req_index];
  assign w_policy_victim = WAY_W'(w_rr_req);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SET_NUM; s++) begin
        r_rr[s] <= '0;
      end
    end else if (upd_valid && upd_fill) begin
      r_rr[upd_index] <= w_rr_upd_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      victim_valid <= req_valid;
      if (req_valid) begin
        victim_way <= w_victim_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_way_replacer.sv
// ============================================================================
// Module  : tb_cache_way_replacer
// Brief   : Scoreboard bench for cache_way_replacer; expectations follow
//           REPLACE_PLRU_EN when defined, round-robin otherwise.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_way_replacer;

  logic       clk;
  logic       resetn;
  logic       req_valid;
  logic [6:0] req_index;
  logic [3:0] req_way_valid;
  logic       victim_valid;
  logic [1:0] victim_way;
  logic       upd_valid;
  logic [6:0] upd_index;
  logic [1:0] upd_way;
  logic       upd_fill;

  int         n_vec;
  int         n_bad;
  logic [1:0] exp_q [$];
  logic [1:0] exp_v;

  cache_way_replacer #(
    .WAY_NUM (4),
    .SET_NUM (128)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_index     (req_index),
    .req_way_valid (req_way_valid),
    .victim_valid  (victim_valid),
    .victim_way    (victim_way),
    .upd_valid     (upd_valid),
    .upd_index     (upd_index),
    .upd_way       (upd_way),
    .upd_fill      (upd_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every presented result is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && victim_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_victim: got way %0d with no query pending", victim_way);
        end else begin
          exp_v = exp_q.pop_front();
          if (victim_way !== exp_v) begin
            n_bad++;
            $display("FAIL victim_way: got %0d, expected %0d", victim_way, exp_v);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic step(input logic rv, input logic [6:0] ri, input logic [3:0] wv,
                      input logic [1:0] ev, input logic uv, input logic [6:0] ui,
                      input logic [1:0] uw, input logic uf);
    @(negedge clk);
    req_valid     = rv;
    req_index     = ri;
    req_way_valid = wv;
    upd_valid     = uv;
    upd_index     = ui;
    upd_way       = uw;
    upd_fill      = uf;
    if (rv) exp_q.push_back(ev);
  endtask

  task automatic query(input logic [6:0] ri, input logic [3:0] wv, input logic [1:0] ev);
    step(1'b1, ri, wv, ev, 1'b0, 7'd0, 2'd0, 1'b0);
  endtask

  task automatic upd(input logic [6:0] ui, input logic [1:0] uw, input logic uf);
    step(1'b0, 7'd0, 4'hF, 2'd0, 1'b1, ui, uw, uf);
  endtask

  task automatic idle();
    step(1'b0, 7'd0, 4'hF, 2'd0, 1'b0, 7'd0, 2'd0, 1'b0);
  endtask

`ifdef REPLACE_PLRU_EN
  localparam logic [1:0] E_S7_A   = 2'd2;
  localparam logic [1:0] E_S7_B   = 2'd1;
  localparam logic [1:0] E_BYPASS = 2'd2;
`else
  localparam logic [1:0] E_S7_A   = 2'd0;
  localparam logic [1:0] E_S7_B   = 2'd0;
  localparam logic [1:0] E_BYPASS = 2'd1;
`endif

  initial begin
    n_vec         = 0;
    n_bad         = 0;
    resetn        = 1'b0;
    req_valid     = 1'b0;
    req_index     = '0;
    req_way_valid = 4'hF;
    upd_valid     = 1'b0;
    upd_index     = '0;
    upd_way       = '0;
    upd_fill      = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_valid", {1'b0, victim_valid}, 2'd0);
    check("reset_way", victim_way, 2'd0);
    resetn = 1'b1;

    query(7'd5, 4'b1111, 2'd0);
    query(7'd3, 4'b1011, 2'd2);
    upd(7'd7, 2'd0, 1'b0);
    query(7'd7, 4'b1111, E_S7_A);
    upd(7'd7, 2'd2, 1'b0);
    query(7'd7, 4'b1111, E_S7_B);
    step(1'b1, 7'd1, 4'b1111, E_BYPASS, 1'b1, 7'd1, 2'd0, 1'b1);
    step(1'b1, 7'd2, 4'b1111, 2'd0,     1'b1, 7'd1, 2'd0, 1'b1);

`ifdef REPLACE_PLRU_EN
    upd(7'd9, 2'd0, 1'b1);
    upd(7'd9, 2'd1, 1'b1);
    query(7'd9, 4'b1111, 2'd2);
    upd(7'd9, 2'd2, 1'b0);
    query(7'd9, 4'b1111, 2'd0);
`else
    upd(7'd9, 2'd3, 1'b1);
    upd(7'd9, 2'd2, 1'b0);
    query(7'd9, 4'b1111, 2'd1);
    upd(7'd9, 2'd0, 1'b1);
    upd(7'd9, 2'd1, 1'b1);
    query(7'd9, 4'b1111, 2'd3);
    upd(7'd9, 2'd1, 1'b0);
    query(7'd9, 4'b1111, 2'd3);
    query(7'd9, 4'b1110, 2'd0);
    upd(7'd9, 2'd2, 1'b1);
    query(7'd9, 4'b1111, 2'd0);
`endif
    query(7'd9, 4'b0000, 2'd0);
    query(7'd9, 4'b0111, 2'd3);
    idle();
    @(negedge clk);
    check("idle_valid", {1'b0, victim_valid}, 2'd0);
    check("idle_hold_way", victim_way, 2'd3);

    // Query in flight when reset hits: its result must vanish without a clock edge.
    query(7'd1, 4'b1101, 2'd1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_valid", {1'b0, victim_valid}, 2'd0);
    check("async_reset_way", victim_way, 2'd0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    query(7'd9, 4'b1111, 2'd0);
    query(7'd7, 4'b1111, 2'd0);
    query(7'd1, 4'b1111, 2'd0);
    idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 2'(exp_q.size()), 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
